// File: rtl/nios2_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_mul_pkg
//  Description : Shared definitions for the Nios II multiply pipeline:
//                operation encodings, op-field width and the helper that
//                turns an op code into signed-correction flags.
//  Revision    : 1.0  initial release
// ============================================================================
package nios2_mul_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] MUL_OP_LO  = 2'd0;  // low half, sign-agnostic
    localparam logic [OP_W-1:0] MUL_OP_XSS = 2'd1;  // high half, signed x signed
    localparam logic [OP_W-1:0] MUL_OP_XSU = 2'd2;  // high half, signed x unsigned
    localparam logic [OP_W-1:0] MUL_OP_XUU = 2'd3;  // high half, unsigned x unsigned

    typedef struct packed {
        logic a_signed;
        logic b_signed;
    } mul_sign_t;

    // Which operands are treated as two's complement for the high-half fixup.
    function automatic mul_sign_t mul_sign_flags(input logic [OP_W-1:0] op);
        mul_sign_t f;
        f.a_signed = (op == MUL_OP_XSS) || (op == MUL_OP_XSU);
        f.b_signed = (op == MUL_OP_XSS);
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nios2_mul_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_mul_pipe_if
//  Description : Issue-side and result-side handshake bundle of the multiply
//                pipeline. master = execute stage / writeback consumer,
//                slave = the pipeline itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface nios2_mul_pipe_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) ();
    import nios2_mul_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] in_src1;
    logic [DATA_W-1:0] in_src2;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );

endinterface
`default_nettype wire

// File: rtl/nios2_mul_half_cell.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_mul_half_cell
//  Description : H x H unsigned multiplier with a registered, enabled output.
//                No reset on the product register so it folds into a DSP
//                block's output register.
//  Revision    : 1.0  initial release
// ============================================================================
module nios2_mul_half_cell #(
    parameter int H = 16
) (
    input  logic           clk,
    input  logic           en_i,
    input  logic [H-1:0]   a_i,
    input  logic [H-1:0]   b_i,
    output logic [2*H-1:0] p_o
);

    logic [2*H-1:0] p_q;

    // Capture the full-width unsigned product whenever the pipe advances.
    always_ff @(posedge clk) begin
        if (en_i) begin
            p_q <= {{H{1'b0}}, a_i} * {{H{1'b0}}, b_i};
        end
    end

    assign p_o = p_q;

endmodule
`default_nettype wire

// File: rtl/nios2_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_mul_pipe
//  Description : Stall-aware, fixed-latency multiply pipeline. Operands are
//                split into half-width partial products (four DSP cells),
//                summed to the full unsigned product, corrected for signed
//                operands and the low or high half is delivered with its tag.
//                Stages: S1 operands -> S2 partial products -> S3 summed
//                product -> output register (fixup/select).
//  Revision    : 1.0  initial release
// ============================================================================
module nios2_mul_pipe
    import nios2_mul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    nios2_mul_pipe_if.slave  bus
);

    localparam int H  = DATA_W / 2;
    localparam int PW = 2 * DATA_W;

    // Global advance: everything moves unless a result is parked unclaimed.
    logic adv;

    // Stage valids and output registers
    logic              s1_valid_q;
    logic              s2_valid_q;
    logic              s3_valid_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_result_q;
    logic [TAG_W-1:0]  out_tag_q;

    // S1: operands and side-band
    logic [DATA_W-1:0] s1_a_q;
    logic [DATA_W-1:0] s1_b_q;
    logic [OP_W-1:0]   s1_op_q;
    logic [TAG_W-1:0]  s1_tag_q;

    // S2: side-band and combined correction term (products live in the cells)
    logic [OP_W-1:0]   s2_op_q;
    logic [TAG_W-1:0]  s2_tag_q;
    logic [DATA_W-1:0] s2_corr_q;

    // S3: full unsigned product plus side-band
    logic [OP_W-1:0]   s3_op_q;
    logic [TAG_W-1:0]  s3_tag_q;
    logic [DATA_W-1:0] s3_corr_q;
    logic [PW-1:0]     s3_prod_q;

    // Combinational next-state values
    mul_sign_t         s1_flags;
    logic [DATA_W-1:0] corr_d;
    logic [DATA_W-1:0] ll_p;
    logic [DATA_W-1:0] lh_p;
    logic [DATA_W-1:0] hl_p;
    logic [DATA_W-1:0] hh_p;
    logic [DATA_W:0]   mid_sum_d;
    logic [PW-1:0]     prod_d;
    logic [DATA_W-1:0] hi_d;
    logic [DATA_W-1:0] result_d;

    assign adv          = ~(out_valid_q & ~bus.out_ready);
    assign bus.in_ready = adv;

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_tag    = out_tag_q;

    // Signed operands are handled by subtracting the other operand from the
    // high half once per negative signed operand; both terms are folded
    // into one modulo-2^DATA_W value here.
    assign s1_flags = mul_sign_flags(s1_op_q);
    assign corr_d   = ((s1_flags.a_signed && s1_a_q[DATA_W-1]) ? s1_b_q : '0)
                    + ((s1_flags.b_signed && s1_b_q[DATA_W-1]) ? s1_a_q : '0);

    nios2_mul_half_cell #(.H(H)) u_cell_ll (
        .clk  (clk),
        .en_i (adv),
        .a_i  (s1_a_q[H-1:0]),
        .b_i  (s1_b_q[H-1:0]),
        .p_o  (ll_p)
    );

    nios2_mul_half_cell #(.H(H)) u_cell_lh (
        .clk  (clk),
        .en_i (adv),
        .a_i  (s1_a_q[H-1:0]),
        .b_i  (s1_b_q[DATA_W-1:H]),
        .p_o  (lh_p)
    );

    nios2_mul_half_cell #(.H(H)) u_cell_hl (
        .clk  (clk),
        .en_i (adv),
        .a_i  (s1_a_q[DATA_W-1:H]),
        .b_i  (s1_b_q[H-1:0]),
        .p_o  (hl_p)
    );

    nios2_mul_half_cell #(.H(H)) u_cell_hh (
        .clk  (clk),
        .en_i (adv),
        .a_i  (s1_a_q[DATA_W-1:H]),
        .b_i  (s1_b_q[DATA_W-1:H]),
        .p_o  (hh_p)
    );

    // Cross terms can carry one bit beyond DATA_W; keep it.
    assign mid_sum_d = {1'b0, lh_p} + {1'b0, hl_p};
    assign prod_d    = {{DATA_W{1'b0}}, ll_p}
                     + ({{(DATA_W-1){1'b0}}, mid_sum_d} << H)
                     + {hh_p, {DATA_W{1'b0}}};

    assign hi_d     = s3_prod_q[PW-1:DATA_W] - s3_corr_q;
    assign result_d = (s3_op_q == MUL_OP_LO) ? s3_prod_q[DATA_W-1:0] : hi_d;

    // Valid chain and output register; reset wins over advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s3_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else if (adv) begin
            s1_valid_q  <= bus.in_valid;
            s2_valid_q  <= s1_valid_q;
            s3_valid_q  <= s2_valid_q;
            out_valid_q <= s3_valid_q;
            if (s3_valid_q) begin
                out_result_q <= result_d;
                out_tag_q    <= s3_tag_q;
            end
        end
    end

    // Datapath registers; contents of bubble stages are don't-care.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_a_q    <= bus.in_src1;
            s1_b_q    <= bus.in_src2;
            s1_op_q   <= bus.in_op;
            s1_tag_q  <= bus.in_tag;
            s2_op_q   <= s1_op_q;
            s2_tag_q  <= s1_tag_q;
            s2_corr_q <= corr_d;
            s3_op_q   <= s2_op_q;
            s3_tag_q  <= s2_tag_q;
            s3_corr_q <= s2_corr_q;
            s3_prod_q <= prod_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nios2_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nios2_mul_pipe
//  Description : Self-checking bench. Three pipelines (16/32/64-bit) share
//                one stimulus stream (operands truncated per width) and one
//                handshake; a scoreboard holds reference results per width.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nios2_mul_pipe;
    import nios2_mul_pkg::*;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [1:0]       in_op;
    logic [63:0]      src1;
    logic [63:0]      src2;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    int checks  = 0;
    int errors  = 0;
    int retired = 0;

    always #5 clk = ~clk;

    nios2_mul_pipe_if #(.DATA_W(16), .TAG_W(TAG_W)) if16 ();
    nios2_mul_pipe_if #(.DATA_W(32), .TAG_W(TAG_W)) if32 ();
    nios2_mul_pipe_if #(.DATA_W(64), .TAG_W(TAG_W)) if64 ();

    assign if16.in_valid = in_valid;  assign if16.in_op = in_op;  assign if16.in_tag = in_tag;
    assign if16.in_src1 = src1[15:0]; assign if16.in_src2 = src2[15:0]; assign if16.out_ready = out_ready;
    assign if32.in_valid = in_valid;  assign if32.in_op = in_op;  assign if32.in_tag = in_tag;
    assign if32.in_src1 = src1[31:0]; assign if32.in_src2 = src2[31:0]; assign if32.out_ready = out_ready;
    assign if64.in_valid = in_valid;  assign if64.in_op = in_op;  assign if64.in_tag = in_tag;
    assign if64.in_src1 = src1;       assign if64.in_src2 = src2;       assign if64.out_ready = out_ready;

    nios2_mul_pipe #(.DATA_W(16), .TAG_W(TAG_W)) u_dut16 (.clk(clk), .reset(reset), .bus(if16));
    nios2_mul_pipe #(.DATA_W(32), .TAG_W(TAG_W)) u_dut32 (.clk(clk), .reset(reset), .bus(if32));
    nios2_mul_pipe #(.DATA_W(64), .TAG_W(TAG_W)) u_dut64 (.clk(clk), .reset(reset), .bus(if64));

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [63:0]      r16;
        logic [63:0]      r32;
        logic [63:0]      r64;
    } exp_t;

    exp_t sb[$];

    // Reference: sign-extend per op to 128 bits, multiply, pick half.
    function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input int w);
        logic [127:0] mask, ae, be, p, r;
        mask = (128'd1 << w) - 128'd1;
        ae = {64'd0, a} & mask;
        be = {64'd0, b} & mask;
        if ((op == 2'd1 || op == 2'd2) && ae[w-1]) ae = ae | ~mask;
        if (op == 2'd1 && be[w-1]) be = be | ~mask;
        p = ae * be;
        r = (op == 2'd0) ? (p & mask) : ((p >> w) & mask);
        return r[63:0];
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return ~64'd0;
            2:       return 64'h8000_8000_8000_8000;
            3:       return 64'h7FFF_7FFF_7FFF_7FFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Scoreboard: push at accept, pop and compare at result handshake.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            sb.delete();
        end else begin
            if (if32.out_valid && out_ready) begin
                checks++;
                if (if16.out_valid !== 1'b1 || if64.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL width_sync out_valid16=%b out_valid64=%b required 1", if16.out_valid, if64.out_valid);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result tag=%0d result=%h required no result", if32.out_tag, if32.out_result);
                end else begin
                    e = sb.pop_front();
                    retired++;
                    checks++;
                    if (if32.out_tag !== e.tag || if16.out_tag !== e.tag || if64.out_tag !== e.tag) begin
                        errors++;
                        $display("FAIL sb_tag got %0d/%0d/%0d required %0d", if16.out_tag, if32.out_tag, if64.out_tag, e.tag);
                    end
                    checks++;
                    if (if16.out_result !== e.r16[15:0] || if32.out_result !== e.r32[31:0] || if64.out_result !== e.r64) begin
                        errors++;
                        $display("FAIL sb_result tag=%0d got %h/%h/%h required %h/%h/%h", e.tag,
                                 if16.out_result, if32.out_result, if64.out_result, e.r16[15:0], e.r32[31:0], e.r64);
                    end
                end
            end
            if (in_valid && if32.in_ready) begin
                e.tag = in_tag;
                e.r16 = ref_mul(in_op, src1, src2, 16);
                e.r32 = ref_mul(in_op, src1, src2, 32);
                e.r64 = ref_mul(in_op, src1, src2, 64);
                sb.push_back(e);
            end
        end
    end

    // Present one op (caller is just after a rising edge); returns just after its accept edge.
    task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [TAG_W-1:0] tag);
        int guard;
        in_valid = 1'b1; in_op = op; src1 = a; src2 = b; in_tag = tag;
        guard = 0;
        forever begin
            @(negedge clk);
            if (if32.in_ready) break;
            guard++;
            if (guard > 200) begin
                checks++; errors++;
                $display("FAIL issue_timeout in_ready=%b required 1 within 200 cycles", if32.in_ready);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag, output logic [31:0] res,
                           output logic [TAG_W-1:0] rtag, output int lat);
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(op, {32'd0, a}, {32'd0, b}, tag);
        in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            if (if32.out_valid) break;
            @(posedge clk);
            lat++;
        end
        res  = if32.out_result;
        rtag = if32.out_tag;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 2'd0; src1 = '0; src2 = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (if32.out_valid !== 1'b0 || if16.out_valid !== 1'b0 || if64.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b%b%b required 000", if16.out_valid, if32.out_valid, if64.out_valid);
        end
        checks++;
        if (if32.out_result !== 32'd0) begin
            errors++; $display("FAIL reset_out_result got %h required 0", if32.out_result);
        end
        checks++;
        if (if32.out_tag !== '0) begin
            errors++; $display("FAIL reset_out_tag got %0d required 0", if32.out_tag);
        end
        checks++;
        if (if32.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b required 1", if32.in_ready);
        end
    endtask

    task automatic test_mul_basic();
        logic [31:0] res; logic [TAG_W-1:0] rtag; int lat;
        run_one(MUL_OP_LO, 32'h0001_0003, 32'h0002_0005, 5'd17, res, rtag, lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL mul_latency got %0d required 3", lat); end
        checks++;
        if (res !== 32'h000B_000F) begin errors++; $display("FAIL mul_result got %h required 000b000f", res); end
        checks++;
        if (rtag !== 5'd17) begin errors++; $display("FAIL mul_tag got %0d required 17", rtag); end
    endtask

    task automatic test_high_ops();
        logic [1:0]  ops [5] = '{MUL_OP_XSS, MUL_OP_XUU, MUL_OP_XSU, MUL_OP_XSS, MUL_OP_LO};
        logic [31:0] as  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] exs [5] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000, 32'h0000_0000};
        logic [31:0] res; logic [TAG_W-1:0] rtag; int lat;
        for (int i = 0; i < 5; i++) begin
            run_one(ops[i], as[i], as[i], 5'(i + 1), res, rtag, lat);
            checks++;
            if (res !== exs[i] || lat != 3) begin
                errors++;
                $display("FAIL high_op%0d result=%h lat=%0d required %h lat=3", i, res, lat, exs[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int start = retired;
        fork
            begin
                @(posedge clk); #1;
                for (int i = 0; i < 10; i++) issue(2'(i % 4), rnd64(), rnd64(), 5'(i));
                in_valid = 1'b0;
            end
            begin
                logic stalled_prev = 1'b0;
                logic [31:0] held_res = '0;
                logic [TAG_W-1:0] held_tag = '0;
                @(posedge clk); #1;
                for (int c = 0; c < 24; c++) begin
                    out_ready = !(c >= 5 && c <= 8);
                    @(negedge clk);
                    checks++;
                    if (if32.in_ready !== !(if32.out_valid && !out_ready)) begin
                        errors++;
                        $display("FAIL b2b_in_ready cycle=%0d got %b required %b", c, if32.in_ready, !(if32.out_valid && !out_ready));
                    end
                    if (stalled_prev) begin
                        checks++;
                        if (if32.out_valid !== 1'b1 || if32.out_result !== held_res || if32.out_tag !== held_tag) begin
                            errors++;
                            $display("FAIL b2b_hold cycle=%0d got v=%b %h/%0d required v=1 %h/%0d", c,
                                     if32.out_valid, if32.out_result, if32.out_tag, held_res, held_tag);
                        end
                    end
                    stalled_prev = if32.out_valid && !out_ready;
                    held_res = if32.out_result;
                    held_tag = if32.out_tag;
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("b2b");
        checks++;
        if (retired - start != 10) begin
            errors++; $display("FAIL b2b_count got %0d required 10", retired - start);
        end
    endtask

    task automatic test_reset_flush();
        logic [31:0] res; logic [TAG_W-1:0] rtag; int lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(MUL_OP_LO,  64'h1111, 64'h2222, 5'd21);
        issue(MUL_OP_XSS, 64'h3333, 64'h4444, 5'd22);
        issue(MUL_OP_XUU, 64'h5555, 64'h6666, 5'd23);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (if32.out_valid !== 1'b0 || if32.out_result !== 32'd0 || if32.out_tag !== '0) begin
            errors++;
            $display("FAIL flush_outputs got v=%b %h/%0d required v=0 0/0", if32.out_valid, if32.out_result, if32.out_tag);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (if32.out_valid !== 1'b0) begin
                errors++; $display("FAIL flush_stale cycle=%0d out_valid=%b required 0", k, if32.out_valid);
            end
        end
        run_one(MUL_OP_XUU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, res, rtag, lat);
        checks++;
        if (lat != 3 || res !== ref_mul(MUL_OP_XUU, 64'h1234_5678, 64'h9ABC_DEF0, 32)) begin
            errors++;
            $display("FAIL flush_next result=%h lat=%0d required %h lat=3", res, lat,
                     ref_mul(MUL_OP_XUU, 64'h1234_5678, 64'h9ABC_DEF0, 32));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit done = 1'b0;
        int start = retired;
        fork
            begin
                @(posedge clk); #1;
                for (int n = 0; n < 8000; n++) begin
                    while ($urandom_range(0, 9) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    issue(2'(n % 4), rnd64(), rnd64(), 5'(n));
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                @(posedge clk); #1;
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("random");
        checks++;
        if (retired - start != 8000) begin
            errors++; $display("FAIL random_count got %0d required 8000", retired - start);
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_high_ops();
        test_back_to_back();
        test_reset_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog simulation did not finish within 3ms");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/nios2_mul_pipe.md
# nios2_mul_pipe

Parametrised, stall-aware multiply pipeline for the Nios II-class CPU datapath. Supersedes the fixed three-partial-product multiply cell: it splits DATA_W operands into half-width partial products, sums them internally and delivers either the low or the high half of the full product for signed, unsigned or mixed-sign operands. It sits between the execute stage (issue side) and the writeback mux (result side), with valid/ready handshakes on both sides and a tag carried alongside each operation.

## Interface
- DATA_W, 32, operand/result width; even, 8..64
- TAG_W, 5, width of pass-through tag (destination register index)
- clk  in  1  clock, all logic rising-edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  pipeline accepts operation this cycle
- in_op  in  2  operation select (see Operation)
- in_src1  in  DATA_W  operand A
- in_src2  in  DATA_W  operand B
- in_tag  in  TAG_W  opaque tag
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result this cycle
- out_result  out  DATA_W  selected product half
- out_tag  out  TAG_W  tag of the result's operation

## Operation
- Op encoding: 0 MUL (low DATA_W of product, sign-agnostic), 1 MULXSS (high half, A signed, B signed), 2 MULXSU (high half, A signed, B unsigned), 3 MULXUU (high half, both unsigned).
- H = DATA_W/2. Unsigned partial products: LL = A[H-1:0]*B[H-1:0], LH = A[H-1:0]*B[DATA_W-1:H], HL = A[DATA_W-1:H]*B[H-1:0], HH = A[DATA_W-1:H]*B[DATA_W-1:H], each 2H bits.
- Unsigned full product P = LL + ((LH+HL) << H) + (HH << DATA_W), computed at 2*DATA_W bits, no truncation of carries.
- Signed correction on high half only: hi = P[2*DATA_W-1:DATA_W] − (A_signed & A[MSB] ? B : 0) − (B_signed & B[MSB] ? A : 0), modulo 2^DATA_W. MUL returns P[DATA_W-1:0] with no correction.
- Stage 1 (S1): register operands, op, tag. Stage 2 (S2): register the four partial products plus correction terms. Stage 3 (S3): sum, correct, select; registered into out_result.
- Each stage has a valid bit. Global advance enable adv = ~(out_valid & ~out_ready). When adv=0 all stage registers and valids hold.
- in_ready = adv. Operation accepted on in_valid & in_ready. Bubbles propagate as valid=0; bubbles do not collapse (fixed-latency pipe, simple global stall).
- Data registers of invalid stages may hold stale values; out_result/out_tag are only meaningful when out_valid=1.

## Timing
- Latency: accepted at edge N → out_valid=1 after edge N+3 when no stall intervenes. Throughput one op/cycle.
- out_valid high with out_ready low: out_result, out_tag, out_valid held stable until the handshake cycle; in_ready low in the same cycles (combinational from out_valid, out_ready).
- Simultaneous out_ready and in_valid on a full pipe: result retires and new op enters in the same edge.
- Reset: all three valid bits 0, out_valid 0, out_result 0, out_tag 0, in_ready 1 from the first cycle after reset. Reset mid-operation discards all in-flight ops; no result emerges for them.
- Reset has priority over advance in the same cycle.

## Structure
- Package nios2_mul_pkg: op encoding constants (MUL_OP_LO, MUL_OP_XSS, MUL_OP_XSU, MUL_OP_XUU), op-field width, helper function for the signed-correction flags.
- One sub-module: nios2_mul_half_cell, an H×H unsigned multiplier with registered output and enable (instantiated 4×, enable = adv), mapping to dedicated DSP blocks.
- Top holds stage valids, stall logic, tag/op pipeline, final adder and correction.

## Test plan
- DATA_W=32, MUL 0x0001_0003 × 0x0002_0005, out_ready=1 → out_result 0x000B_000F exactly 3 cycles after accept, tag echoed.
- MULXSS 0xFFFF_FFFF × 0xFFFF_FFFF → 0x0000_0000; MULXUU same operands → 0xFFFF_FFFE; MULXSU → 0xFFFF_FFFF.
- MULXSS 0x8000_0000 × 0x8000_0000 → 0x4000_0000; MUL same → 0x0000_0000.
- Back-to-back 10 ops with tags 0..9, out_ready held low cycles 5–8 → in_ready low same cycles, outputs stable, all 10 results in order with no loss or duplication.
- Reset asserted with 3 ops in flight → out_valid 0 next cycle, out_result 0, no stale result afterwards; next op completes normally with 3-cycle latency.
- DATA_W=16 and DATA_W=64 builds: 2000 random ops per op code compared against a 2*DATA_W-bit reference product model.
